// File: rtl/flappy_game_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : flappy_game_engine_if
// Description : Frame-timing inputs and renderer-facing position bus of the
//               flappy game engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface flappy_game_engine_if;
    logic       vsync;
    logic       btn_flap;
    logic [9:0] PosVPajaro;
    logic [9:0] PosHTubo1;
    logic [9:0] PosVTubo1;
    logic [9:0] PosHTubo2;
    logic [9:0] PosVTubo2;
    logic       Chocar;
    logic [7:0] Score;

    // Engine side
    modport master (
        input  vsync, btn_flap,
        output PosVPajaro, PosHTubo1, PosVTubo1, PosHTubo2, PosVTubo2, Chocar, Score
    );

    // Renderer / video-timing side
    modport slave (
        output vsync, btn_flap,
        input  PosVPajaro, PosHTubo1, PosVTubo1, PosHTubo2, PosVTubo2, Chocar, Score
    );
endinterface
`default_nettype wire

// File: rtl/flappy_game_engine.sv
`default_nettype none
// ============================================================================
// Module      : flappy_game_engine
// Description : Per-frame game state update (bird physics, pipe scroll, gap
//               randomisation, collision, score) on each vsync rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module flappy_game_engine #(
    parameter int GRAVITY      = 1,
    parameter int FLAP_VEL     = -6,
    parameter int VMAX         = 8,
    parameter int PIPE_SPEED   = 2,
    parameter int PIPE_SPAN    = 640,
    parameter int CRASH_FRAMES = 120,
    parameter int INIT_H1      = 400,
    parameter int INIT_V1      = 300,
    parameter int INIT_H2      = 720,
    parameter int INIT_V2      = 200,
    parameter int INIT_BIRD    = 240
) (
    input  wire logic             dclk,
    input  wire logic             clr,
    flappy_game_engine_if.master  bus
);
    localparam int CW = $clog2(CRASH_FRAMES + 1);
    localparam logic signed [7:0] GRAV_S = 8'(GRAVITY);
    localparam logic signed [7:0] FLAP_S = 8'(FLAP_VEL);
    localparam logic signed [7:0] VMAX_S = 8'(VMAX);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_PLAY = 2'd1, S_CRASH = 2'd2} state_t;

    state_t             state_q, state_d;
    logic               vs_q;
    logic               btn_s1_q, btn_s2_q, btn_s3_q;
    logic [7:0]         lfsr_q;
    logic               pend_q, pend_d;
    logic               upd_q, upd_d;
    logic signed [7:0]  vel_q, vel_d;
    logic [9:0]         bird_q, bird_d;
    logic [9:0]         h1_q, h1_d, v1_q, v1_d, h2_q, h2_d, v2_q, v2_d;
    logic               chocar_q, chocar_d;
    logic [7:0]         score_q, score_d;
    logic [CW-1:0]      fcnt_q, fcnt_d;

    logic               tick, flap_edge, hit, do_play, wrap1, wrap2, pass1, pass2;
    logic signed [7:0]  vel_inc, vel_play;
    logic signed [10:0] bird_sum;
    logic [9:0]         bird_play, h1_play, h2_play, v1_play, v2_play;
    logic [8:0]         score_sum;

    assign tick      = bus.vsync & ~vs_q;
    assign flap_edge = btn_s2_q & ~btn_s3_q;

    function automatic logic [9:0] scroll(input logic [9:0] h);
        if (h < 10'(PIPE_SPEED))
            return h + 10'(PIPE_SPAN - PIPE_SPEED);
        return h - 10'(PIPE_SPEED);
    endfunction

    // Bird overlaps the pipe columns and sits outside the open gap rows.
    // bird-32 < v-128 is rewritten as bird+96 < v to stay unsigned.
    function automatic logic pipe_hit(input logic [9:0] h, input logic [9:0] v,
                                      input logic [9:0] b);
        logic xh, yh;
        xh = (h <= 10'd160) && (({1'b0, h} + 11'd64) >= 11'd129);
        yh = (({1'b0, b} + 11'd96) < {1'b0, v}) || (b >= v);
        return xh && yh;
    endfunction

    // Candidate PLAY-frame update, computed every cycle and applied on a tick
    always_comb begin
        vel_inc   = vel_q + GRAV_S;
        vel_play  = pend_q ? FLAP_S : ((vel_inc > VMAX_S) ? VMAX_S : vel_inc);
        bird_sum  = $signed({1'b0, bird_q}) + $signed({{3{vel_play[7]}}, vel_play});
        if (bird_sum < 11'sd32)
            bird_play = 10'd32;
        else if (bird_sum > 11'sd479)
            bird_play = 10'd479;
        else
            bird_play = bird_sum[9:0];
        wrap1     = h1_q < 10'(PIPE_SPEED);
        wrap2     = h2_q < 10'(PIPE_SPEED);
        h1_play   = scroll(h1_q);
        h2_play   = scroll(h2_q);
        v1_play   = wrap1 ? (10'd160 + {2'b00, lfsr_q}) : v1_q;
        v2_play   = wrap2 ? (10'd160 + {2'b00, lfsr_q}) : v2_q;
        pass1     = (h1_q >= 10'd64) && (h1_play < 10'd64);
        pass2     = (h2_q >= 10'd64) && (h2_play < 10'd64);
        score_sum = {1'b0, score_q} + {8'd0, pass1} + {8'd0, pass2};
        hit       = pipe_hit(h1_q, v1_q, bird_q) || pipe_hit(h2_q, v2_q, bird_q)
                    || (bird_q == 10'd479);
    end

    // Next-state and game register updates
    always_comb begin
        state_d  = state_q;
        vel_d    = vel_q;
        bird_d   = bird_q;
        h1_d     = h1_q;
        v1_d     = v1_q;
        h2_d     = h2_q;
        v2_d     = v2_q;
        chocar_d = chocar_q;
        score_d  = score_q;
        fcnt_d   = fcnt_q;
        do_play  = 1'b0;
        // Every tick consumes or discards a pending flap.
        pend_d   = flap_edge | (pend_q & ~tick);
        case (state_q)
            S_IDLE: begin
                if (tick && pend_q) begin
                    state_d = S_PLAY;
                    do_play = 1'b1;
                end
            end
            S_PLAY: begin
                if (upd_q && hit) begin
                    chocar_d = 1'b1;
                    fcnt_d   = '0;
                    state_d  = S_CRASH;
                end else if (tick) begin
                    do_play = 1'b1;
                end
            end
            S_CRASH: begin
                if (tick) begin
                    if (fcnt_q < CW'(CRASH_FRAMES)) begin
                        fcnt_d = fcnt_q + CW'(1);
                    end else if (pend_q) begin
                        state_d  = S_IDLE;
                        vel_d    = '0;
                        bird_d   = 10'(INIT_BIRD);
                        h1_d     = 10'(INIT_H1);
                        v1_d     = 10'(INIT_V1);
                        h2_d     = 10'(INIT_H2);
                        v2_d     = 10'(INIT_V2);
                        chocar_d = 1'b0;
                        score_d  = '0;
                        fcnt_d   = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (do_play) begin
            vel_d   = vel_play;
            bird_d  = bird_play;
            h1_d    = h1_play;
            v1_d    = v1_play;
            h2_d    = h2_play;
            v2_d    = v2_play;
            score_d = score_sum[8] ? 8'hFF : score_sum[7:0];
        end
        upd_d = do_play;
    end

    // State registers, synchronisers and free-running LFSR
    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            state_q  <= S_IDLE;
            vs_q     <= 1'b0;
            btn_s1_q <= 1'b0;
            btn_s2_q <= 1'b0;
            btn_s3_q <= 1'b0;
            lfsr_q   <= 8'hA5;
            pend_q   <= 1'b0;
            upd_q    <= 1'b0;
            vel_q    <= '0;
            bird_q   <= 10'(INIT_BIRD);
            h1_q     <= 10'(INIT_H1);
            v1_q     <= 10'(INIT_V1);
            h2_q     <= 10'(INIT_H2);
            v2_q     <= 10'(INIT_V2);
            chocar_q <= 1'b0;
            score_q  <= '0;
            fcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            vs_q     <= bus.vsync;
            btn_s1_q <= bus.btn_flap;
            btn_s2_q <= btn_s1_q;
            btn_s3_q <= btn_s2_q;
            lfsr_q   <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            pend_q   <= pend_d;
            upd_q    <= upd_d;
            vel_q    <= vel_d;
            bird_q   <= bird_d;
            h1_q     <= h1_d;
            v1_q     <= v1_d;
            h2_q     <= h2_d;
            v2_q     <= v2_d;
            chocar_q <= chocar_d;
            score_q  <= score_d;
            fcnt_q   <= fcnt_d;
        end
    end

    assign bus.PosVPajaro = bird_q;
    assign bus.PosHTubo1  = h1_q;
    assign bus.PosVTubo1  = v1_q;
    assign bus.PosHTubo2  = h2_q;
    assign bus.PosVTubo2  = v2_q;
    assign bus.Chocar     = chocar_q;
    assign bus.Score      = score_q;
endmodule
`default_nettype wire

// File: tb/tb_flappy_game_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_flappy_game_engine
// Description : Scoreboard bench for flappy_game_engine; four instances with
//               different start positions share vsync/flap/clear stimulus and
//               are compared each frame against a behavioural game model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flappy_game_engine;
    localparam int ND = 4;

    typedef struct packed {
        logic [9:0] bird;
        logic [9:0] h1;
        logic [9:0] v1;
        logic [9:0] h2;
        logic [9:0] v2;
        logic       choc;
        logic [7:0] score;
    } obs_t;
    typedef obs_t [ND-1:0] frame_t;

    logic dclk = 1'b0;
    logic clr  = 1'b1;
    logic vsync, btn;
    logic [7:0] tb_lfsr;
    int n_tests = 0;
    int n_fail  = 0;
    frame_t exp_q[$];
    obs_t act [ND];

    // Behavioural game model, one slot per instance (0 idle, 1 play, 2 crash)
    int st [ND], bird [ND], vel [ND], score [ND], fcnt [ND];
    int ph [ND][2], pv [ND][2], ih [ND][2], iv [ND][2];
    bit choc [ND], pend [ND];

    always #5 dclk = ~dclk;

    flappy_game_engine_if bus0 ();
    flappy_game_engine_if bus1 ();
    flappy_game_engine_if bus2 ();
    flappy_game_engine_if bus3 ();

    assign bus0.vsync = vsync; assign bus0.btn_flap = btn;
    assign bus1.vsync = vsync; assign bus1.btn_flap = btn;
    assign bus2.vsync = vsync; assign bus2.btn_flap = btn;
    assign bus3.vsync = vsync; assign bus3.btn_flap = btn;

    flappy_game_engine u_dut0 (.dclk(dclk), .clr(clr), .bus(bus0));
    flappy_game_engine #(.INIT_H1(3), .INIT_H2(66)) u_dut1 (.dclk(dclk), .clr(clr), .bus(bus1));
    flappy_game_engine #(.INIT_H1(66), .INIT_H2(66)) u_dut2 (.dclk(dclk), .clr(clr), .bus(bus2));
    flappy_game_engine #(.INIT_H1(170), .INIT_V1(200)) u_dut3 (.dclk(dclk), .clr(clr), .bus(bus3));

    assign act[0] = {bus0.PosVPajaro, bus0.PosHTubo1, bus0.PosVTubo1, bus0.PosHTubo2, bus0.PosVTubo2, bus0.Chocar, bus0.Score};
    assign act[1] = {bus1.PosVPajaro, bus1.PosHTubo1, bus1.PosVTubo1, bus1.PosHTubo2, bus1.PosVTubo2, bus1.Chocar, bus1.Score};
    assign act[2] = {bus2.PosVPajaro, bus2.PosHTubo1, bus2.PosVTubo1, bus2.PosHTubo2, bus2.PosVTubo2, bus2.Chocar, bus2.Score};
    assign act[3] = {bus3.PosVPajaro, bus3.PosHTubo1, bus3.PosVTubo1, bus3.PosHTubo2, bus3.PosVTubo2, bus3.Chocar, bus3.Score};

    // Gap-randomiser sequence: x^8+x^6+x^5+x^4+1 from 8'hA5, one step per clock
    always @(posedge dclk or posedge clr) begin
        if (clr) tb_lfsr <= 8'hA5;
        else     tb_lfsr <= {tb_lfsr[6:0], tb_lfsr[7] ^ tb_lfsr[5] ^ tb_lfsr[4] ^ tb_lfsr[3]};
    end

    function automatic void m_reset(int i);
        st[i] = 0; bird[i] = 240; vel[i] = 0; score[i] = 0; fcnt[i] = 0;
        choc[i] = 1'b0; pend[i] = 1'b0;
        for (int j = 0; j < 2; j++) begin ph[i][j] = ih[i][j]; pv[i][j] = iv[i][j]; end
    endfunction

    function automatic void m_play(int i, bit flap, int lf);
        int passes = 0;
        bit crash;
        vel[i]  = flap ? -6 : ((vel[i] + 1 > 8) ? 8 : vel[i] + 1);
        bird[i] = bird[i] + vel[i];
        if (bird[i] < 32)  bird[i] = 32;
        if (bird[i] > 479) bird[i] = 479;
        for (int j = 0; j < 2; j++) begin
            int old = ph[i][j];
            if (old < 2) begin ph[i][j] = old + 638; pv[i][j] = 160 + lf; end
            else ph[i][j] = old - 2;
            if (old >= 64 && ph[i][j] < 64) passes++;
        end
        score[i] = (score[i] + passes > 255) ? 255 : score[i] + passes;
        crash = (bird[i] == 479);
        for (int j = 0; j < 2; j++)
            if (ph[i][j] <= 160 && ph[i][j] + 64 >= 129 &&
                (bird[i] - 32 < pv[i][j] - 128 || bird[i] >= pv[i][j])) crash = 1'b1;
        if (crash) begin choc[i] = 1'b1; st[i] = 2; fcnt[i] = 0; end
    endfunction

    function automatic void m_tick(int i, int lf);
        bit f = pend[i];
        pend[i] = 1'b0;
        if (st[i] == 0) begin
            if (f) begin st[i] = 1; m_play(i, 1'b1, lf); end
        end else if (st[i] == 1) begin
            m_play(i, f, lf);
        end else begin
            if (fcnt[i] < 120) fcnt[i]++;
            else if (f) m_reset(i);
        end
    endfunction

    function automatic obs_t m_obs(int i);
        obs_t o;
        o.bird = 10'(bird[i]); o.h1 = 10'(ph[i][0]); o.v1 = 10'(pv[i][0]);
        o.h2 = 10'(ph[i][1]); o.v2 = 10'(pv[i][1]); o.choc = choc[i]; o.score = 8'(score[i]);
        return o;
    endfunction

    task automatic chk_obs(input string name, input int i, input obs_t w);
        obs_t g = act[i];
        n_tests++;
        if (g !== w) begin
            n_fail++;
            $display("FAIL %s dut%0d: got bird=%0d h1=%0d v1=%0d h2=%0d v2=%0d chocar=%0b score=%0d; want bird=%0d h1=%0d v1=%0d h2=%0d v2=%0d chocar=%0b score=%0d",
                     name, i, g.bird, g.h1, g.v1, g.h2, g.v2, g.choc, g.score,
                     w.bird, w.h1, w.v1, w.h2, w.v2, w.choc, w.score);
        end
    endtask

    task automatic chk(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // One video frame: optional async clear, optional flap press, then vsync rise
    task automatic frame(input bit flap, input bit do_clr);
        frame_t e;
        @(negedge dclk);
        vsync = 1'b0;
        if (do_clr) begin
            #1 clr = 1'b1;
            for (int i = 0; i < ND; i++) m_reset(i);
            #1;
            for (int i = 0; i < ND; i++) chk_obs("clr_async", i, m_obs(i));
            @(negedge dclk);
            clr = 1'b0;
        end
        repeat (2) @(negedge dclk);
        if (flap) begin
            btn = 1'b1;
            repeat (3) @(negedge dclk);
            btn = 1'b0;
            for (int i = 0; i < ND; i++) pend[i] = 1'b1;
        end
        repeat (6) @(negedge dclk);
        for (int i = 0; i < ND; i++) begin
            m_tick(i, int'(tb_lfsr));
            e[i] = m_obs(i);
        end
        exp_q.push_back(e);
        vsync = 1'b1;
        repeat (8) @(negedge dclk);
    endtask

    // Monitor: after each vsync rise, compare settled outputs with the queued prediction
    initial begin
        frame_t e;
        forever begin
            @(posedge vsync);
            repeat (4) @(negedge dclk);
            if (exp_q.size() == 0) begin
                chk("scoreboard_empty", 0, 1);
            end else begin
                e = exp_q.pop_front();
                for (int i = 0; i < ND; i++) chk_obs("frame", i, e[i]);
            end
        end
    end

    initial begin
        int k;
        vsync = 1'b0;
        btn   = 1'b0;
        ih[0] = '{400, 720}; iv[0] = '{300, 200};
        ih[1] = '{3, 66};    iv[1] = '{300, 200};
        ih[2] = '{66, 66};   iv[2] = '{300, 200};
        ih[3] = '{170, 720}; iv[3] = '{200, 200};
        for (int i = 0; i < ND; i++) m_reset(i);
        repeat (3) @(negedge dclk);
        for (int i = 0; i < ND; i++) chk_obs("reset", i, m_obs(i));
        clr = 1'b0;

        // Idle frames: nothing moves without a flap
        repeat (10) frame(1'b0, 1'b0);
        chk("idle_bird", int'(bus0.PosVPajaro), 240);
        chk("idle_h1", int'(bus0.PosHTubo1), 400);
        chk("idle_chocar", int'(bus0.Chocar), 0);
        chk("idle_score", int'(bus0.Score), 0);

        // Start with one flap and let the bird coast
        frame(1'b1, 1'b0);
        chk("f1_bird", int'(bus0.PosVPajaro), 234);
        chk("f1_d1_h1", int'(bus1.PosHTubo1), 1);
        chk("f1_d3_chocar", int'(bus3.Chocar), 0);
        frame(1'b0, 1'b0);
        chk("f2_bird", int'(bus0.PosVPajaro), 229);
        chk("f2_d1_h1_wrap", int'(bus1.PosHTubo1), 639);
        chk("f2_d1_v1_range", int'(bus1.PosVTubo1 >= 10'd160 && bus1.PosVTubo1 <= 10'd415), 1);
        chk("f2_d1_score_one", int'(bus1.Score), 1);
        chk("f2_d2_score_two", int'(bus2.Score), 2);
        chk("f2_d3_chocar", int'(bus3.Chocar), 0);
        frame(1'b0, 1'b0);
        chk("f3_bird", int'(bus0.PosVPajaro), 225);
        chk("f3_d3_chocar", int'(bus3.Chocar), 0);
        frame(1'b0, 1'b0);
        chk("f4_bird", int'(bus0.PosVPajaro), 222);
        chk("f4_d3_chocar", int'(bus3.Chocar), 0);
        frame(1'b0, 1'b0);
        chk("f5_d3_chocar", int'(bus3.Chocar), 1);
        chk("f5_d3_h1", int'(bus3.PosHTubo1), 160);
        chk("f5_d3_bird", int'(bus3.PosVPajaro), 220);
        frame(1'b0, 1'b0);
        chk("f6_d3_frozen_h1", int'(bus3.PosHTubo1), 160);
        chk("f6_d3_frozen_bird", int'(bus3.PosVPajaro), 220);

        // Free fall to the floor
        k = 0;
        while (st[0] != 2 && k < 100) begin frame(1'b0, 1'b0); k++; end
        chk("floor_crash_reached", int'(st[0] == 2), 1);
        chk("floor_chocar", int'(bus0.Chocar), 1);
        chk("floor_bird", int'(bus0.PosVPajaro), 479);

        // Crash hold-off: early flap ignored, later flap restarts
        for (int f = 1; f <= 120; f++) begin
            frame(f == 50, 1'b0);
            if (f == 50 || f == 51) chk("crash_flap_ignored", int'(bus0.Chocar), 1);
        end
        frame(1'b1, 1'b0);
        chk("restart_chocar", int'(bus0.Chocar), 0);
        chk("restart_bird", int'(bus0.PosVPajaro), 240);
        chk("restart_h1", int'(bus0.PosHTubo1), 400);
        chk("restart_score", int'(bus0.Score), 0);

        // Randomised play with occasional clears
        for (int f = 0; f < 300; f++)
            frame($urandom_range(0, 4) == 0, $urandom_range(0, 39) == 0);

        // Clear while crashed
        k = 0;
        while (st[0] != 2 && k < 300) begin frame(st[0] == 0, 1'b0); k++; end
        chk("crash_before_clr", int'(bus0.Chocar), 1);
        frame(1'b0, 1'b1);
        chk("after_clr_chocar", int'(bus0.Chocar), 0);

        repeat (10) @(negedge dclk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
